btn_press_arbiter: RTL and testbench
====================================

# btn_press_arbiter

Round-robin scheduler that shares one downstream resource (the step counter / LED driver) between up to N debounced button sources. Each source delivers single-cycle press pulses from its filter's enable output. The block latches them as pending requests and grants exactly one source at a time. It then holds the resource for a fixed number of cycles before the next grant. It sits between the per-button filter/synchronizer chains and the shared counter.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- HOLD_CYCLES, 8, cycles the resource stays granted per press (1..255)
- ID_W, clog2(N_REQ), width of grant_id (derived, not overridden)

Ports:
- clk  input  1  single system clock, all logic rising-edge
- reset  input  1  synchronous, active-high; takes effect on the clk edge where it is sampled high
- req_pulse  input  N_REQ  one-cycle press pulses, bit i = source i
- grant_valid  output  1  one-cycle pulse marking the start of a grant
- grant_id  output  ID_W  index of the current/last granted source
- busy  output  1  high for every cycle of a grant hold
- pending  output  N_REQ  latched, not-yet-served requests
- overflow  output  1  one-cycle pulse: a request was dropped

## Operation
- Reset values: state IDLE, pending 0, grant_valid 0, grant_id 0, busy 0, overflow 0, rr pointer 0, hold timer 0.
- Request latch:
  - req_pulse[i]=1 sets pending[i] on the next edge.
  - If pending[i] is already 1 and not being cleared this cycle, the request is dropped and overflow pulses on the next edge. Multiple drops in one cycle give a single overflow pulse.
- FSM state IDLE:
  - If pending is nonzero, the winner is the first set bit searching upward from the rr pointer, wrapping N_REQ-1 to 0.
  - Next edge: state HOLD, grant_valid=1, busy=1, grant_id=winner, pending[winner] cleared, rr pointer = (winner+1) mod N_REQ, timer = HOLD_CYCLES-1.
- FSM state HOLD:
  - grant_valid returns to 0 after the first cycle.
  - When the timer is greater than 0, it decrements.
  - When the timer equals 0, the next edge goes to IDLE with busy=0.
- grant_id holds its value through HOLD and IDLE until the next grant.
- Simultaneous events:
  - When req_pulse[i] arrives on the same cycle pending[i] is cleared by its grant, pending[i] stays 1 (re-armed). overflow does not pulse.
  - Requests arriving during HOLD latch normally. They are never granted mid-hold.
- Reset mid-hold aborts the grant immediately. All outputs take their reset values on that edge, and pending requests are discarded.

## Timing
- req_pulse at edge t: pending visible after t. Earliest grant_valid is after edge t+1.
- A grant occupies exactly HOLD_CYCLES cycles of busy=1.
- At least one IDLE cycle (busy=0) separates consecutive grants.
- Back-to-back grant_valid pulses are therefore HOLD_CYCLES+1 cycles apart.
- All outputs are registered. There is no combinational path from req_pulse to any output.

## Structure
- Shared package btn_pkg holds:
  - the state encoding (IDLE=1'b0, HOLD=1'b1)
  - the clog2 constant function
  - the HOLD_CYCLES width constant (8 bits)
- Sub-module rr_picker is combinational. Its inputs are pending and the rr pointer. Its outputs are the winner index and any_valid. It is reused by other arbitration blocks.
- The top module holds the pending register, FSM, timer and output registers.

## Test plan
- Reset then single request: req_pulse=4'b0100 for 1 cycle, HOLD_CYCLES=8.
  - Required: grant_valid 2 edges later with grant_id=2.
  - Required: busy high for exactly 8 cycles, then pending=0.
- Rotation: all four requests pulsed on the same cycle with pointer 0.
  - Required: grants in order 0,1,2,3, spaced 9 cycles apart.
  - Required: the next lone request on source 0 is granted after source 3 with pointer wrap.
- Overflow: req_pulse[1] pulsed twice during a hold while pending[1]=1.
  - Required: one overflow pulse per dropped pulse, and only one grant for source 1.
- Re-arm collision: req_pulse[1] asserted on the exact cycle source 1 is granted.
  - Required: pending[1] stays 1, overflow 0, and a second grant to 1 follows after the hold.
- Reset mid-hold: reset asserted in cycle 3 of a hold with pending=4'b1001.
  - Required: on the next edge busy=0, pending=0, grant_id=0, and no further grants.
- HOLD_CYCLES=1 boundary: two requests.
  - Required: busy pulses 1 cycle each and grants are 2 cycles apart.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared constants for the button-press arbitration blocks.
package btn_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  localparam int HOLD_W = 8;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first set pending bit at or above ptr, wrapping.
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] pending,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  winner,
  output logic             any_valid
);

  int idx;

  // Walk offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    winner    = '0;
    any_valid = |pending;
    idx       = 0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      idx = (int'(ptr) + off) % N_REQ;
      if (pending[idx]) winner = ID_W'(idx);
    end
  end

endmodule

// File: rtl/btn_press_arbiter.sv
// Round-robin arbiter granting one debounced button source a fixed-length hold.
module btn_press_arbiter
  import btn_pkg::*;
#(
  parameter  int N_REQ       = 4,
  parameter  int HOLD_CYCLES = 8,
  localparam int ID_W        = clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req_pulse,
  output logic             grant_valid,
  output logic [ID_W-1:0]  grant_id,
  output logic             busy,
  output logic [N_REQ-1:0] pending,
  output logic             overflow
);

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(N_REQ - 1);

  logic [0:0]        state;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   winner;
  logic              any_valid;
  logic [HOLD_W-1:0] timer;
  logic              grant_now;
  logic [N_REQ-1:0]  clr;

  rr_picker #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
    .pending   (pending),
    .ptr       (ptr),
    .winner    (winner),
    .any_valid (any_valid)
  );

  assign grant_now = (state == ST_IDLE) && any_valid;

  for (genvar i = 0; i < N_REQ; i++) begin : g_clr
    assign clr[i] = grant_now && (winner == ID_W'(i));
  end

  // A pulse landing on the bit being granted re-arms it instead of dropping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      pending     <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      busy        <= 1'b0;
      overflow    <= 1'b0;
      ptr         <= '0;
      timer       <= '0;
    end else begin
      pending  <= (pending & ~clr) | req_pulse;
      overflow <= |(req_pulse & pending & ~clr);
      case (state)
        ST_IDLE: begin
          grant_valid <= 1'b0;
          if (any_valid) begin
            state       <= ST_HOLD;
            grant_valid <= 1'b1;
            busy        <= 1'b1;
            grant_id    <= winner;
            ptr         <= (winner == LAST_ID) ? '0 : winner + ID_W'(1);
            timer       <= HOLD_LOAD;
          end
        end
        default: begin
          grant_valid <= 1'b0;
          if (timer != '0) begin
            timer <= timer - HOLD_W'(1);
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_press_arbiter.sv
// Directed bench for btn_press_arbiter: HOLD_CYCLES=8 instance plus a HOLD_CYCLES=1 instance.
module tb_btn_press_arbiter;

  logic       clk = 1'b0;
  logic       reset, reset1;
  logic [3:0] req, req1;
  logic       gv, gv1, busy, busy1, ovf, ovf1;
  logic [1:0] gid, gid1;
  logic [3:0] pend, pend1;

  int total  = 0;
  int passed = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  btn_press_arbiter #(.N_REQ(4), .HOLD_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .req_pulse(req), .grant_valid(gv), .grant_id(gid),
    .busy(busy), .pending(pend), .overflow(ovf)
  );

  btn_press_arbiter #(.N_REQ(4), .HOLD_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset1), .req_pulse(req1), .grant_valid(gv1), .grant_id(gid1),
    .busy(busy1), .pending(pend1), .overflow(ovf1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Advance at least one edge, stop on the edge that raises grant_valid.
  task automatic wait_grant(input string tag, input int lim);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!gv && n < lim);
    chk({tag, "_seen"}, int'(gv), 1);
  endtask

  initial begin
    int n, g, t0, tp;
    reset = 1'b1; reset1 = 1'b1; req = '0; req1 = '0;
    tick(); tick();
    chk("rst_gv", gv, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pend", pend, 0);
    chk("rst_gid", gid, 0);
    chk("rst_ovf", ovf, 0);
    reset = 1'b0; reset1 = 1'b0;
    tick();

    // single request on source 2
    req = 4'b0100;
    tick();
    req = '0;
    chk("single_pend", pend, 4'b0100);
    chk("single_gv_early", gv, 0);
    tick();
    chk("single_gv", gv, 1);
    chk("single_gid", gid, 2);
    chk("single_pend_clr", pend, 0);
    n = 1;
    tick();
    chk("single_gv_pulse", gv, 0);
    while (busy && n < 20) begin
      n++;
      tick();
    end
    chk("single_busy_len", n, 8);
    chk("single_pend_end", pend, 0);
    chk("single_gid_hold", gid, 2);

    // rotation from pointer 0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req = 4'b1111;
    tick();
    req = '0;
    tp = 0;
    for (int k = 0; k < 4; k++) begin
      wait_grant("rot", 30);
      chk("rot_gid", gid, k);
      if (k > 0) chk("rot_space", cyc - tp, 9);
      tp = cyc;
    end
    // pointer must wrap to 0 after source 3: 0 beats 3
    req = 4'b1001;
    tick();
    req = '0;
    wait_grant("wrap", 30);
    chk("wrap_gid0", gid, 0);
    chk("wrap_space", cyc - tp, 9);
    wait_grant("wrap2", 30);
    chk("wrap_gid3", gid, 3);
    n = 0;
    while (busy && n < 20) begin
      n++;
      tick();
    end

    // overflow: two extra pulses on source 1 while it is pending
    req = 4'b0001;
    tick();
    req = 4'b0010;
    tick();
    req = '0;
    chk("ovf_grant0", gid, 0);
    chk("ovf_pend1", pend, 4'b0010);
    chk("ovf_none", ovf, 0);
    tick();
    req = 4'b0010;
    tick();
    req = '0;
    chk("ovf_pulse1", ovf, 1);
    tick();
    chk("ovf_clear1", ovf, 0);
    req = 4'b0010;
    tick();
    req = '0;
    chk("ovf_pulse2", ovf, 1);
    chk("ovf_busy", busy, 1);
    tick();
    chk("ovf_clear2", ovf, 0);
    wait_grant("ovf_g1", 30);
    chk("ovf_gid1", gid, 1);
    chk("ovf_pend_after", pend, 0);
    g = 0;
    repeat (15) begin
      tick();
      if (gv) g++;
    end
    chk("ovf_single_grant", g, 0);

    // re-arm: pulse on source 1 exactly on its grant edge
    req = 4'b0010;
    tick();
    tick();
    req = '0;
    chk("rearm_gv", gv, 1);
    chk("rearm_gid", gid, 1);
    chk("rearm_pend", pend, 4'b0010);
    chk("rearm_ovf", ovf, 0);
    t0 = cyc;
    wait_grant("rearm_g2", 30);
    chk("rearm_gid2", gid, 1);
    chk("rearm_space", cyc - t0, 9);

    // reset in cycle 3 of a hold with pending=1001
    req = 4'b1001;
    tick();
    req = '0;
    tick();
    chk("rmh_pend", pend, 4'b1001);
    chk("rmh_busy_pre", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rmh_busy", busy, 0);
    chk("rmh_pend0", pend, 0);
    chk("rmh_gid", gid, 0);
    chk("rmh_gv", gv, 0);
    g = 0;
    repeat (20) begin
      tick();
      if (gv || busy) g++;
    end
    chk("rmh_no_grant", g, 0);

    // HOLD_CYCLES=1 instance: two requests
    req1 = 4'b0011;
    tick();
    req1 = '0;
    tick();
    chk("h1_gv_a", gv1, 1);
    chk("h1_gid_a", gid1, 0);
    chk("h1_busy_a", busy1, 1);
    tick();
    chk("h1_busy_gap", busy1, 0);
    chk("h1_gv_gap", gv1, 0);
    tick();
    chk("h1_gv_b", gv1, 1);
    chk("h1_gid_b", gid1, 1);
    chk("h1_busy_b", busy1, 1);
    tick();
    chk("h1_busy_end", busy1, 0);
    chk("h1_pend_end", pend1, 0);
    chk("h1_ovf", ovf1, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
